// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - redirect request channel between branch_redirect_ctrl and fetch
interface branch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - taken-transfer PC redirect/stall/flush sequencer (optional counters: BRANCH_STATS_EN)
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_is_branch,
    input  logic                  ex_branch_taken,
    input  logic                  ex_is_jal,
    input  logic                  ex_is_jalr,
    input  logic [XLEN-1:0]       ex_target,
    branch_redirect_ctrl_if.master redir,
    output logic                  stall_ex,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  misalign_exc,
    output logic [XLEN-1:0]       misalign_addr
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_taken,
    output logic [31:0]           stat_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            misalign_exc_q, misalign_exc_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

    logic            take;
    logic [XLEN-1:0] tgt;
    logic            accept;
    logic            stall_c;
    logic            flush_c;

    always_comb begin
        take   = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & ex_branch_taken));
        // JALR clears bit 0 of the computed sum; JAL/branch targets pass through.
        tgt    = ex_is_jalr ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
        accept = redirect_valid_q & redir.redirect_ready;

        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        misalign_exc_d   = 1'b0;
        misalign_addr_d  = misalign_addr_q;
        stall_c          = 1'b0;
        flush_c          = 1'b0;

        case (state_q)
            IDLE: begin
                if (take) begin
                    if (!tgt[1]) begin
                        stall_c          = 1'b1;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = tgt;
                        state_d          = REDIRECT;
                    end else begin
                        // Misaligned target traps instead of redirecting; no stall.
                        misalign_exc_d  = 1'b1;
                        misalign_addr_d = tgt;
                    end
                end
            end
            REDIRECT: begin
                if (accept) begin
                    flush_c          = 1'b1;
                    redirect_valid_d = 1'b0;
                    if (FLUSH_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = 3'(FLUSH_CYCLES - 1);
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= 3'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misalign_exc_q   <= 1'b0;
            misalign_addr_q  <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_exc_q   <= misalign_exc_d;
            misalign_addr_q  <= misalign_addr_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign stall_ex             = stall_c & ~reset;
    assign flush_ifid           = flush_c & ~reset;
    assign flush_idex           = flush_c & ~reset;
    assign redir.redirect_valid = redirect_valid_q;
    assign redir.redirect_pc    = redirect_pc_q;
    assign misalign_exc         = misalign_exc_q;
    assign misalign_addr        = misalign_addr_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_taken_q, stat_taken_d;
    logic [31:0] stat_stall_cycles_q, stat_stall_cycles_d;

    always_comb begin
        stat_branches_d     = stat_branches_q;
        stat_taken_d        = stat_taken_q;
        stat_stall_cycles_d = stat_stall_cycles_q;
        if (state_q == IDLE && ex_valid && ex_is_branch) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (state_q == REDIRECT && accept) begin
            stat_taken_d = stat_taken_q + 32'd1;
        end
        if (stall_c) begin
            stat_stall_cycles_d = stat_stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q     <= 32'd0;
            stat_taken_q        <= 32'd0;
            stat_stall_cycles_q <= 32'd0;
        end else begin
            stat_branches_q     <= stat_branches_d;
            stat_taken_q        <= stat_taken_d;
            stat_stall_cycles_q <= stat_stall_cycles_d;
        end
    end

    assign stat_branches     = stat_branches_q;
    assign stat_taken        = stat_taken_q;
    assign stat_stall_cycles = stat_stall_cycles_q;
`endif

endmodule
